id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 21 ++
 rtl/forward_mux.sv | 31 +++
 rtl/id_ex_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU command encodings, the hard-wired zero register
// and a register-match helper used by hazard and forwarding logic.
package mips_pkg;
  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_cmd_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A writer only matters if it writes a real register (r0 is never a dependency).
  function automatic logic reg_hit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
    return wr && (dst != REG_ZERO) && (dst == src);
  endfunction
endpackage

// File: rtl/forward_mux.sv
// Operand forwarding select for one source register. Forwarding exists only when
// FORWARD_EN is defined; otherwise the held register-file data passes straight through.
module forward_mux
  import mips_pkg::*;
(
  input  logic [4:0]  src_addr,
  input  logic [31:0] src_data,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_dest,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_dest,
  input  logic [31:0] memwb_result,
  output logic [31:0] operand
);
`ifdef FORWARD_EN
  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    operand = src_data;
    if (reg_hit(exmem_reg_write, exmem_dest, src_addr))
      operand = exmem_result;
    else if (reg_hit(memwb_reg_write, memwb_dest, src_addr))
      operand = memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{src_addr, exmem_reg_write, exmem_dest, exmem_result,
                        memwb_reg_write, memwb_dest, memwb_result};
  assign operand = src_data;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, hazard bubble insertion and operand
// selection. Define FORWARD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int COMMAND_LENGTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                rs_addr,
  input  logic [4:0]                rt_addr,
  input  logic [4:0]                dest,
  input  logic [31:0]               rs_data,
  input  logic [31:0]               rt_data,
  input  logic [31:0]               imm,
  input  logic                      alu_src,
  input  logic [COMMAND_LENGTH-1:0] command_in,
  input  logic                      reg_write_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      flush,
  input  logic                      out_ready,
  input  logic                      exmem_reg_write,
  input  logic [4:0]                exmem_dest,
  input  logic [31:0]               exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [4:0]                memwb_dest,
  input  logic [31:0]               memwb_result,
  output logic                      out_valid,
  output logic [31:0]               input_1,
  output logic [31:0]               input_2,
  output logic [COMMAND_LENGTH-1:0] command,
  output logic [4:0]                dest_out,
  output logic                      reg_write,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               store_data,
  output logic                      hazard_stall
);
  logic [4:0]  held_rs, held_rt;
  logic [31:0] held_rs_data, held_rt_data, held_imm;
  logic        held_alu_src;
  logic [31:0] operand_a, operand_b;
  logic        uses_held;
  logic        capture;

  assign uses_held = out_valid &&
                     (reg_hit(1'b1, dest_out, rs_addr) || reg_hit(1'b1, dest_out, rt_addr));

`ifdef FORWARD_EN
  // Only a load's result is too late to forward.
  assign hazard_stall = in_valid && uses_held && mem_read;
`else
  assign hazard_stall = in_valid && ((uses_held && reg_write) ||
                                     reg_hit(exmem_reg_write, exmem_dest, rs_addr) ||
                                     reg_hit(exmem_reg_write, exmem_dest, rt_addr));
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard_stall;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      reg_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      dest_out     <= REG_ZERO;
      held_rs      <= REG_ZERO;
      held_rt      <= REG_ZERO;
      held_rs_data <= '0;
      held_rt_data <= '0;
      held_imm     <= '0;
      held_alu_src <= 1'b0;
      command      <= COMMAND_LENGTH'(ALU_ADD);
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      reg_write    <= reg_write_in;
      mem_read     <= mem_read_in;
      mem_write    <= mem_write_in;
      dest_out     <= dest;
      held_rs      <= rs_addr;
      held_rt      <= rt_addr;
      held_rs_data <= rs_data;
      held_rt_data <= rt_data;
      held_imm     <= imm;
      held_alu_src <= alu_src;
      command      <= command_in;
    end else if (out_valid && out_ready) begin
      // Drained with nothing to take its place (or a hazard): leave a bubble.
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  forward_mux u_fwd_rs (
    .src_addr(held_rs), .src_data(held_rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
    .operand(operand_a)
  );

  forward_mux u_fwd_rt (
    .src_addr(held_rt), .src_data(held_rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
    .operand(operand_b)
  );

  assign input_1    = operand_a;
  assign input_2    = held_alu_src ? held_imm : operand_b;
  assign store_data = operand_b;
endmodule
